game_cmd_sequencer: RTL and testbench

Command front-end for the console game state machine (gameFSM). Conditions the three raw player buttons (start, pause, reset), arbitrates between them, and issues at most one legal single-cycle command pulse at a time. Each pulse is held in a handshake until the game FSM's state output changes or a timeout expires. It also auto-issues a reset after the game has sat in GAMEOVER for a programmable hold time.

---
 rtl/game_cmd_sequencer.sv | 199 +++++++++++++++++++
 tb/tb_game_cmd_sequencer.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/game_cmd_sequencer.sv
// Command front-end for the game FSM: debounces the three player buttons and
// issues one legal, acknowledged command pulse at a time (plus GAMEOVER auto-reset).
module game_cmd_sequencer #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int ACK_TIMEOUT     = 32,
  parameter int GAMEOVER_HOLD   = 1024
) (
  input  logic       clk,
  input  logic       resetFSM,
  input  logic       btnStart,
  input  logic       btnPause,
  input  logic       btnReset,
  input  logic [2:0] stateIn,
  output logic       startGame,
  output logic       pauseGame,
  output logic       reset,
  output logic       busy,
  output logic       cmdErr
);

  localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TOW = $clog2(ACK_TIMEOUT + 1);
  localparam int HLW = $clog2(GAMEOVER_HOLD + 1);

  localparam logic [2:0] ST_START    = 3'd0;
  localparam logic [2:0] ST_PLAYING  = 3'd1;
  localparam logic [2:0] ST_PAUSE    = 3'd2;
  localparam logic [2:0] ST_RESET    = 3'd3;
  localparam logic [2:0] ST_GAMEOVER = 3'd4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_ACK
  } seq_state_t;

  // Command vectors are ordered by priority: bit 0 reset, bit 1 start, bit 2 pause.
  logic [2:0] btn_raw;
  logic [2:0] rise;

  assign btn_raw = {btnPause, btnStart, btnReset};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_btn
      logic           sync1_reg;
      logic           sync2_reg;
      logic           deb_reg;
      logic           deb_prev_reg;
      logic [DBW-1:0] cnt_reg;

      always_ff @(posedge clk or negedge resetFSM) begin
        if (!resetFSM) begin
          sync1_reg    <= 1'b0;
          sync2_reg    <= 1'b0;
          deb_reg      <= 1'b0;
          deb_prev_reg <= 1'b0;
          cnt_reg      <= '0;
        end else begin
          sync1_reg    <= btn_raw[gi];
          sync2_reg    <= sync1_reg;
          deb_prev_reg <= deb_reg;
          if (sync2_reg != deb_reg) begin
            // This sample is the DEBOUNCE_CYCLES-th consecutive disagreement.
            if (cnt_reg == DBW'(DEBOUNCE_CYCLES - 1)) begin
              deb_reg <= sync2_reg;
              cnt_reg <= '0;
            end else begin
              cnt_reg <= cnt_reg + DBW'(1);
            end
          end else begin
            cnt_reg <= '0;
          end
        end
      end

      assign rise[gi] = deb_reg & ~deb_prev_reg;
    end
  endgenerate

  // GAMEOVER hold counter; fires only on the step into saturation, so once per visit.
  logic [HLW-1:0] hold_reg;
  logic           auto_fire;

  assign auto_fire = (stateIn == ST_GAMEOVER) && (hold_reg == HLW'(GAMEOVER_HOLD - 1));

  always_ff @(posedge clk or negedge resetFSM) begin
    if (!resetFSM) begin
      hold_reg <= '0;
    end else if (stateIn == ST_GAMEOVER) begin
      if (hold_reg != HLW'(GAMEOVER_HOLD)) begin
        hold_reg <= hold_reg + HLW'(1);
      end
    end else begin
      hold_reg <= '0;
    end
  end

  logic [2:0] legal;

  always_comb begin
    legal = 3'b000;
    case (stateIn)
      ST_START:    legal = 3'b011;
      ST_PLAYING:  legal = 3'b101;
      ST_PAUSE:    legal = 3'b011;
      ST_RESET:    legal = 3'b000;
      ST_GAMEOVER: legal = 3'b011;
      default:     legal = 3'b000;
    endcase
  end

  seq_state_t     state_reg, state_next;
  logic [2:0]     pend_reg, pend_next;
  logic [2:0]     cmd_reg, cmd_next;
  logic [2:0]     ack_ref_reg, ack_ref_next;
  logic [TOW-1:0] tmo_reg, tmo_next;
  logic [2:0]     avail;
  logic [2:0]     sel;
  logic [2:0]     pulse_next;
  logic           busy_next;
  logic           err_next;

  always_comb begin
    state_next   = state_reg;
    cmd_next     = cmd_reg;
    ack_ref_next = ack_ref_reg;
    tmo_next     = tmo_reg;
    err_next     = cmdErr;
    avail        = pend_reg;
    sel          = 3'b000;

    case (state_reg)
      S_IDLE: begin
        avail = pend_reg & legal;
        if (avail[0]) begin
          sel = 3'b001;
        end else if (avail[1]) begin
          sel = 3'b010;
        end else if (avail[2]) begin
          sel = 3'b100;
        end
        if (sel != 3'b000) begin
          state_next   = S_ISSUE;
          cmd_next     = sel;
          ack_ref_next = stateIn;
        end
      end
      S_ISSUE: begin
        // The timer counts cycles since the pulse; the first WAIT_ACK cycle is the second.
        state_next = S_WAIT_ACK;
        tmo_next   = TOW'(2);
      end
      S_WAIT_ACK: begin
        if (stateIn != ack_ref_reg) begin
          state_next = S_IDLE;
        end else if (tmo_reg == TOW'(ACK_TIMEOUT)) begin
          err_next   = 1'b1;
          state_next = S_IDLE;
        end else begin
          tmo_next = tmo_reg + TOW'(1);
        end
      end
      default: state_next = S_IDLE;
    endcase

    // New edges always set their flag, even if the same flag was just served.
    pend_next  = (avail & ~sel) | rise | {2'b00, auto_fire};
    pulse_next = (state_next == S_ISSUE) ? cmd_next : 3'b000;
    busy_next  = (state_next != S_IDLE);
  end

  always_ff @(posedge clk or negedge resetFSM) begin
    if (!resetFSM) begin
      state_reg   <= S_IDLE;
      pend_reg    <= 3'b000;
      cmd_reg     <= 3'b000;
      ack_ref_reg <= 3'b000;
      tmo_reg     <= '0;
      startGame   <= 1'b0;
      pauseGame   <= 1'b0;
      reset       <= 1'b0;
      busy        <= 1'b0;
      cmdErr      <= 1'b0;
    end else begin
      state_reg   <= state_next;
      pend_reg    <= pend_next;
      cmd_reg     <= cmd_next;
      ack_ref_reg <= ack_ref_next;
      tmo_reg     <= tmo_next;
      reset       <= pulse_next[0];
      startGame   <= pulse_next[1];
      pauseGame   <= pulse_next[2];
      busy        <= busy_next;
      cmdErr      <= err_next;
    end
  end

endmodule

// File: tb/tb_game_cmd_sequencer.sv
// Bench for game_cmd_sequencer: directed scenarios plus randomized buttons and a
// reactive game-FSM stand-in, all checked cycle by cycle against a behavioural model.
`timescale 1ns/1ps
module tb_game_cmd_sequencer;

  localparam int DEB  = 4;
  localparam int ACK  = 8;
  localparam int HOLD = 16;

  logic       clk = 1'b0;
  logic       resetFSM = 1'b0;
  logic       btnStart = 1'b0;
  logic       btnPause = 1'b0;
  logic       btnReset = 1'b0;
  logic [2:0] stateIn = 3'd0;
  logic       startGame, pauseGame, reset, busy, cmdErr;

  game_cmd_sequencer #(
    .DEBOUNCE_CYCLES(DEB),
    .ACK_TIMEOUT    (ACK),
    .GAMEOVER_HOLD  (HOLD)
  ) dut (
    .clk      (clk),
    .resetFSM (resetFSM),
    .btnStart (btnStart),
    .btnPause (btnPause),
    .btnReset (btnReset),
    .stateIn  (stateIn),
    .startGame(startGame),
    .pauseGame(pauseGame),
    .reset    (reset),
    .busy     (busy),
    .cmdErr   (cmdErr)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Behavioural model. Command bit order: 0 reset, 1 start, 2 pause.
  int             edge_n = 0;
  logic [2:0]     m_s1, m_s2, m_deb, m_deb_prev, m_pend, m_pulse, m_ref;
  logic [DEB-1:0] m_win [3];
  bit             m_active, m_err;
  int             m_issue_edge, m_go_run;

  function automatic logic [2:0] legal_of(input logic [2:0] s);
    logic [2:0] l;
    l[0] = (s <= 3'd4) && (s != 3'd3);
    l[1] = (s == 3'd0) || (s == 3'd2) || (s == 3'd4);
    l[2] = (s == 3'd1);
    return l;
  endfunction

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_deb = '0; m_deb_prev = '0;
    m_pend = '0; m_pulse = '0; m_ref = '0;
    for (int b = 0; b < 3; b++) m_win[b] = '0;
    m_active = 0; m_err = 0; m_issue_edge = 0; m_go_run = 0;
  endtask

  // One rising edge: everything is computed from the values held before the edge.
  task automatic model_step();
    logic [2:0] raw, rise, lg, avail, sel;
    logic       fire;
    raw   = {btnPause, btnStart, btnReset};
    rise  = m_deb & ~m_deb_prev;
    fire  = (stateIn == 3'd4) && (m_go_run == HOLD - 1);
    lg    = legal_of(stateIn);
    avail = m_pend;
    sel   = '0;
    m_pulse = '0;
    if (!m_active) begin
      avail = m_pend & lg;
      if (avail[0]) sel = 3'b001;
      else if (avail[1]) sel = 3'b010;
      else if (avail[2]) sel = 3'b100;
      if (sel != 3'b000) begin
        m_active = 1; m_issue_edge = edge_n; m_ref = stateIn; m_pulse = sel;
      end
    end else if (edge_n >= m_issue_edge + 2) begin
      if (stateIn != m_ref) m_active = 0;
      else if (edge_n - m_issue_edge == ACK) begin
        m_err = 1; m_active = 0;
      end
    end
    m_pend   = (avail & ~sel) | rise | {2'b00, fire};
    m_go_run = (stateIn == 3'd4) ? m_go_run + 1 : 0;
    m_deb_prev = m_deb;
    for (int b = 0; b < 3; b++) begin
      m_win[b] = {m_win[b][DEB-2:0], m_s2[b]};
      if (m_win[b] == {DEB{~m_deb[b]}}) m_deb[b] = ~m_deb[b];
    end
    m_s2 = m_s1;
    m_s1 = raw;
  endtask

  int c_start = 0, c_pause = 0, c_reset = 0;

  task automatic tick();
    @(posedge clk);
    edge_n++;
    if (!resetFSM) model_reset();
    else model_step();
    @(negedge clk);
    check_val("outs{err,busy,rst,pause,start}",
              {27'd0, cmdErr, busy, reset, pauseGame, startGame},
              {27'd0, m_err, m_active, m_pulse[0], m_pulse[2], m_pulse[1]});
    c_start += int'(startGame);
    c_pause += int'(pauseGame);
    c_reset += int'(reset);
    if (startGame || pauseGame || reset)
      $display("edge %0d: pulse start=%0b pause=%0b reset=%0b stateIn=%0d err=%0b",
               edge_n, startGame, pauseGame, reset, stateIn, cmdErr);
  endtask

  task automatic do_reset();
    resetFSM = 1'b0;
    model_reset();
    tick();
    tick();
    resetFSM = 1'b1;
  endtask

  task automatic clr_counts();
    c_start = 0; c_pause = 0; c_reset = 0;
  endtask

  logic [2:0] lvl;
  int         run_left [3];
  logic [2:0] resp_cmd;
  int         resp_wait;
  int         first_rst, t_start;

  initial begin
    model_reset();

    // 1: buttons held through reset; reset then start once released.
    {btnPause, btnStart, btnReset} = 3'b111;
    stateIn = 3'd0;
    clr_counts();
    for (int k = 0; k < 3; k++) tick();
    check_val("s1_no_pulse_in_reset", c_start + c_pause + c_reset, 0);
    resetFSM = 1'b1;
    for (int k = 0; k < 30; k++) tick();
    check_val("s1_reset_cnt", c_reset, 1);
    check_val("s1_start_cnt", c_start, 1);
    check_val("s1_pause_cnt", c_pause, 0);
    {btnPause, btnStart, btnReset} = 3'b000;
    do_reset();

    // 2: short press ignored; held press pulses at edge 8 and waits for ack.
    stateIn = 3'd0;
    clr_counts();
    btnStart = 1'b1;
    for (int k = 0; k < 3; k++) tick();
    btnStart = 1'b0;
    for (int k = 0; k < 12; k++) tick();
    check_val("s2_short_press", c_start, 0);
    btnStart = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      check_val("s2_latency", startGame, k == 8);
      if (k >= 9) check_val("s2_busy", busy, 1);
    end
    btnStart = 1'b0;
    stateIn = 3'd1;
    tick();
    check_val("s2_busy_drop", busy, 0);
    for (int k = 0; k < 8; k++) tick();

    // 3: start+pause together while PLAYING: only pause issues.
    clr_counts();
    btnStart = 1'b1;
    btnPause = 1'b1;
    for (int k = 0; k < 25; k++) begin
      tick();
      if (pauseGame) stateIn = 3'd2;
    end
    btnStart = 1'b0;
    btnPause = 1'b0;
    check_val("s3_pause_cnt", c_pause, 1);
    check_val("s3_start_cnt", c_start, 0);
    check_val("s3_busy", busy, 0);
    for (int k = 0; k < 8; k++) tick();

    // 4: unacknowledged start raises cmdErr 8 cycles after the pulse; sticky.
    do_reset();
    stateIn = 3'd0;
    btnStart = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (k == 10) btnStart = 1'b0;
      if (k == 15) check_val("s4_err_before", cmdErr, 0);
      if (k == 16) check_val("s4_err_rise", cmdErr, 1);
    end
    clr_counts();
    btnStart = 1'b1;
    for (int k = 0; k < 12; k++) tick();
    btnStart = 1'b0;
    for (int k = 0; k < 14; k++) tick();
    check_val("s4_second_start", c_start, 1);
    check_val("s4_err_sticky", cmdErr, 1);
    do_reset();
    check_val("s4_err_clear", cmdErr, 0);

    // 5: GAMEOVER auto-reset fires once per visit.
    stateIn = 3'd4;
    clr_counts();
    for (int k = 0; k < 60; k++) tick();
    check_val("s5_auto_once", c_reset, 1);
    stateIn = 3'd3;
    tick();
    tick();
    stateIn = 3'd4;
    clr_counts();
    for (int k = 0; k < 25; k++) tick();
    check_val("s5_rearm", c_reset, 1);

    // 6: reset and start together in PAUSE: reset first, start after ack.
    do_reset();
    stateIn = 3'd2;
    first_rst = 0;
    t_start = 0;
    btnReset = 1'b1;
    btnStart = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (first_rst != 0 && k == first_rst + 1) stateIn = 3'd0;
      if (reset && first_rst == 0) begin
        first_rst = k;
        stateIn = 3'd3;
      end
      if (startGame && t_start == 0) t_start = k;
    end
    btnReset = 1'b0;
    btnStart = 1'b0;
    check_val("s6_reset_edge", first_rst, 8);
    check_val("s6_start_edge", t_start, 11);
    check_val("s6_gap_ge3", (t_start - first_rst) >= 3, 1);

    // Random phase: bouncing buttons and a responsive (sometimes silent) game FSM.
    do_reset();
    stateIn = 3'd0;
    lvl = 3'b000;
    resp_cmd = 3'b000;
    resp_wait = 0;
    for (int b = 0; b < 3; b++) run_left[b] = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      tick();
      for (int b = 0; b < 3; b++) begin
        if (run_left[b] == 0) begin
          lvl[b] = 1'($urandom_range(0, 1));
          run_left[b] = int'($urandom_range(1, 12));
        end else begin
          run_left[b]--;
        end
      end
      {btnPause, btnStart, btnReset} = lvl;
      if (m_pulse != 3'b000 && $urandom_range(0, 3) != 0) begin
        resp_cmd = m_pulse;
        resp_wait = int'($urandom_range(0, 3));
      end
      if (resp_cmd != 3'b000) begin
        if (resp_wait == 0) begin
          stateIn = resp_cmd[0] ? 3'd3 : (resp_cmd[1] ? 3'd1 : 3'd2);
          resp_cmd = 3'b000;
        end else begin
          resp_wait--;
        end
      end else if (stateIn == 3'd3 && $urandom_range(0, 7) == 0) begin
        stateIn = 3'd0;
      end else if (stateIn == 3'd1 && $urandom_range(0, 59) == 0) begin
        stateIn = 3'd4;
      end else if (stateIn > 3'd4 && $urandom_range(0, 9) == 0) begin
        stateIn = 3'd0;
      end else if ($urandom_range(0, 299) == 0) begin
        stateIn = 3'($urandom_range(5, 7));
      end
      if ($urandom_range(0, 1499) == 0) begin
        resp_cmd = 3'b000;
        do_reset();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
